// File: rtl/up_pkg.sv
// ---------------------------------------------------------------------------
// up_pkg
// Shared definitions for the 8-instruction accumulator microprocessor:
// default datapath widths, accumulator source select encodings and the
// 3-bit opcode values. Both the datapath and the control unit use these.
// ---------------------------------------------------------------------------
package up_pkg;

    localparam int UP_DATA_W = 8;
    localparam int UP_ADDR_W = 5;
    localparam int UP_DEPTH  = 32;

    // Accumulator source select. Code 2'b11 is reserved and loads zero.
    typedef enum logic [1:0] {
        ASEL_ALU  = 2'b00,
        ASEL_IN   = 2'b01,
        ASEL_MEM  = 2'b10,
        ASEL_ZERO = 2'b11
    } asel_e;

    // Instruction opcodes held in IR[7:5].
    typedef enum logic [2:0] {
        OP_LOAD  = 3'b000,
        OP_STORE = 3'b001,
        OP_ADD   = 3'b010,
        OP_SUB   = 3'b011,
        OP_INPUT = 3'b100,
        OP_JZ    = 3'b101,
        OP_JPOS  = 3'b110,
        OP_HALT  = 3'b111
    } opcode_e;

    // Extract the opcode field from an instruction word.
    function automatic logic [2:0] opcode_of(input logic [UP_DATA_W-1:0] instr);
        return instr[UP_DATA_W-1:UP_DATA_W-3];
    endfunction

endpackage

// File: rtl/up_datapath_if.sv
// ---------------------------------------------------------------------------
// up_datapath_if
// Control-unit <-> datapath link: the control word flowing into the
// datapath and the status (IR, Aeq0, Apos) flowing back.
//   master : control unit side (drives control word, reads status)
//   slave  : datapath side     (reads control word, drives status)
// ---------------------------------------------------------------------------
interface up_datapath_if #(
    parameter int DATA_W = up_pkg::UP_DATA_W
) ();

    logic              IRload;
    logic              JMPmux;
    logic              PCload;
    logic              Meminst;
    logic              MemWr;
    logic              Aload;
    logic              Sub;
    logic [1:0]        Asel;

    logic [DATA_W-1:0] IR;
    logic              Aeq0;
    logic              Apos;

    modport master (
        output IRload, JMPmux, PCload, Meminst, MemWr, Aload, Sub, Asel,
        input  IR, Aeq0, Apos
    );

    modport slave (
        input  IRload, JMPmux, PCload, Meminst, MemWr, Aload, Sub, Asel,
        output IR, Aeq0, Apos
    );

endinterface

// File: rtl/up_ram.sv
// ---------------------------------------------------------------------------
// up_ram
// DEPTH x DATA_W single-clock RAM with a registered read port.
// Read is read-before-write: a write and a read of the same address on one
// edge return the previous contents. The external program-load port has
// priority over the datapath store port. The array itself is never reset;
// only the read register is.
// Ports:
//   clk_i, rst_n_i            clock, async active-low reset (read register)
//   addr_i                    datapath address (read and store)
//   mem_wr_i, wdata_i         datapath store enable and data
//   prog_we_i/addr_i/data_i   external program-load write port
//   dout_o                    registered read data
// ---------------------------------------------------------------------------
module up_ram #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 5,
    parameter int DEPTH  = 32
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic              mem_wr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic              prog_we_i,
    input  logic [ADDR_W-1:0] prog_addr_i,
    input  logic [DATA_W-1:0] prog_data_i,
    output logic [DATA_W-1:0] dout_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] dout_q;

    logic              wr_en_s;
    logic [ADDR_W-1:0] wr_addr_s;
    logic [DATA_W-1:0] wr_data_s;

    // Resolve the two write sources; program load wins over a store.
    always_comb begin
        wr_en_s   = 1'b0;
        wr_addr_s = addr_i;
        wr_data_s = wdata_i;
        if (prog_we_i) begin
            wr_en_s   = 1'b1;
            wr_addr_s = prog_addr_i;
            wr_data_s = prog_data_i;
        end else if (mem_wr_i) begin
            wr_en_s   = 1'b1;
            wr_addr_s = addr_i;
            wr_data_s = wdata_i;
        end else begin
            wr_en_s   = 1'b0;
        end
    end

    // Storage array write; contents survive reset.
    always_ff @(posedge clk_i) begin
        if (wr_en_s) begin
            mem_q[wr_addr_s] <= wr_data_s;
        end
    end

    // Read register, loaded every edge; sees pre-write contents.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            dout_q <= {DATA_W{1'b0}};
        end else begin
            dout_q <= mem_q[addr_i];
        end
    end

    assign dout_o = dout_q;

endmodule

// File: rtl/up_datapath.sv
// ---------------------------------------------------------------------------
// up_datapath
// Accumulator datapath of the 8-instruction microprocessor: instruction
// register, program counter, accumulator, adder/subtractor and a 32x8
// synchronous RAM with an external program-load port.
// Ports:
//   CLOCK, RESET_N                  clock, async active-low reset
//   ctrl (up_datapath_if.slave)     control word in; IR, Aeq0, Apos out
//   INPUT                           data switches for the INPUT instruction
//   PROG_WE, PROG_ADDR, PROG_DATA   external RAM program-load port
//   A, PC                           accumulator / program counter for display
// ---------------------------------------------------------------------------
module up_datapath
    import up_pkg::*;
#(
    parameter int DATA_W = UP_DATA_W,
    parameter int ADDR_W = UP_ADDR_W,
    parameter int DEPTH  = UP_DEPTH
) (
    input  logic              CLOCK,
    input  logic              RESET_N,
    up_datapath_if.slave      ctrl,
    input  logic [DATA_W-1:0] INPUT,
    input  logic              PROG_WE,
    input  logic [ADDR_W-1:0] PROG_ADDR,
    input  logic [DATA_W-1:0] PROG_DATA,
    output logic [DATA_W-1:0] A,
    output logic [ADDR_W-1:0] PC
);

    logic [DATA_W-1:0] ir_q, ir_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [DATA_W-1:0] a_q,  a_d;

    logic [ADDR_W-1:0] addr_s;
    logic [DATA_W-1:0] dout_s;
    logic [DATA_W-1:0] alu_s;

    // Memory address: operand field while executing, else the PC.
    always_comb begin
        if (ctrl.Meminst) begin
            addr_s = ir_q[ADDR_W-1:0];
        end else begin
            addr_s = pc_q;
        end
    end

    // Adder/subtractor; results wrap modulo 2**DATA_W, no flags.
    always_comb begin
        if (ctrl.Sub) begin
            alu_s = a_q - dout_s;
        end else begin
            alu_s = a_q + dout_s;
        end
    end

    // Next-state for IR, PC and accumulator.
    always_comb begin
        ir_d = ir_q;
        pc_d = pc_q;
        a_d  = a_q;

        if (ctrl.IRload) begin
            ir_d = dout_s;
        end else begin
            ir_d = ir_q;
        end

        // PC+1 wraps naturally from the top address back to 0.
        if (ctrl.PCload) begin
            if (ctrl.JMPmux) begin
                pc_d = ir_q[ADDR_W-1:0];
            end else begin
                pc_d = pc_q + {{(ADDR_W-1){1'b0}}, 1'b1};
            end
        end else begin
            pc_d = pc_q;
        end

        if (ctrl.Aload) begin
            case (ctrl.Asel)
                ASEL_ALU: a_d = alu_s;
                ASEL_IN:  a_d = INPUT;
                ASEL_MEM: a_d = dout_s;
                default:  a_d = {DATA_W{1'b0}};
            endcase
        end else begin
            a_d = a_q;
        end
    end

    // Architectural registers; reset clears everything at once.
    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            ir_q <= {DATA_W{1'b0}};
            pc_q <= {ADDR_W{1'b0}};
            a_q  <= {DATA_W{1'b0}};
        end else begin
            ir_q <= ir_d;
            pc_q <= pc_d;
            a_q  <= a_d;
        end
    end

    up_ram #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) u_ram (
        .clk_i       (CLOCK),
        .rst_n_i     (RESET_N),
        .addr_i      (addr_s),
        .mem_wr_i    (ctrl.MemWr),
        .wdata_i     (a_q),
        .prog_we_i   (PROG_WE),
        .prog_addr_i (PROG_ADDR),
        .prog_data_i (PROG_DATA),
        .dout_o      (dout_s)
    );

    // Status flags depend on the accumulator register only.
    assign ctrl.IR   = ir_q;
    assign ctrl.Aeq0 = (a_q == {DATA_W{1'b0}});
    assign ctrl.Apos = ~a_q[DATA_W-1];
    assign A         = a_q;
    assign PC        = pc_q;

endmodule

// File: tb/tb_up_datapath.sv
// ---------------------------------------------------------------------------
// tb_up_datapath
// Directed instruction sequences plus randomized control words, checked
// against an instruction-level model of the accumulator machine.
// ---------------------------------------------------------------------------
module tb_up_datapath;
    import up_pkg::*;

    logic       CLOCK = 1'b0;
    logic       RESET_N;
    logic [7:0] INPUT;
    logic       PROG_WE;
    logic [4:0] PROG_ADDR;
    logic [7:0] PROG_DATA;
    logic [7:0] A;
    logic [4:0] PC;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model state
    int m_mem [32];
    int m_a, m_pc, m_ir, m_dout;

    always #5 CLOCK = ~CLOCK;

    up_datapath_if bus ();

    up_datapath dut (
        .CLOCK     (CLOCK),
        .RESET_N   (RESET_N),
        .ctrl      (bus),
        .INPUT     (INPUT),
        .PROG_WE   (PROG_WE),
        .PROG_ADDR (PROG_ADDR),
        .PROG_DATA (PROG_DATA),
        .A         (A),
        .PC        (PC)
    );

    task automatic model_reset();
        m_a = 0; m_pc = 0; m_ir = 0; m_dout = 0;
    endtask

    // One clock of the machine, in plain arithmetic.
    task automatic model_step();
        int addr, rd, na, npc;
        addr = bus.Meminst ? (m_ir % 32) : m_pc;
        rd   = m_mem[addr];
        if (PROG_WE) m_mem[PROG_ADDR] = PROG_DATA;
        else if (bus.MemWr) m_mem[addr] = m_a;
        na = m_a;
        if (bus.Aload) begin
            if (bus.Asel == 2'd0) na = bus.Sub ? (m_a - m_dout + 256) % 256 : (m_a + m_dout) % 256;
            else if (bus.Asel == 2'd1) na = INPUT;
            else if (bus.Asel == 2'd2) na = m_dout;
            else na = 0;
        end
        npc = m_pc;
        if (bus.PCload) npc = bus.JMPmux ? (m_ir % 32) : (m_pc + 1) % 32;
        if (bus.IRload) m_ir = m_dout;
        m_a = na; m_pc = npc; m_dout = rd;
    endtask

    task automatic drive(input logic irl, jmp, pcl, mi, mw, al, sub, input logic [1:0] asel);
        bus.IRload = irl; bus.JMPmux = jmp; bus.PCload = pcl; bus.Meminst = mi;
        bus.MemWr = mw; bus.Aload = al; bus.Sub = sub; bus.Asel = asel;
    endtask

    task automatic tick();
        @(posedge CLOCK);
        model_step();
        #1;
    endtask

    task automatic prog(input logic [4:0] ad, input logic [7:0] d);
        drive(0, 0, 0, 0, 0, 0, 0, 2'd0);
        PROG_WE = 1'b1; PROG_ADDR = ad; PROG_DATA = d;
        tick();
        PROG_WE = 1'b0;
    endtask

    task automatic load_a(input logic [7:0] v);
        drive(0, 0, 0, 0, 0, 1, 0, 2'd1);
        INPUT = v;
        tick();
        drive(0, 0, 0, 0, 0, 0, 0, 2'd0);
    endtask

    // START, FETCH, DECODE, EXECUTE with the given execute-state controls.
    task automatic instr(input logic al, input logic [1:0] asel, input logic sub, mw, pcl);
        drive(0, 0, 0, 0, 0, 0, 0, 2'd0); tick();
        drive(1, 0, 1, 0, 0, 0, 0, 2'd0); tick();
        drive(0, 0, 0, 1, 0, 0, 0, 2'd0); tick();
        drive(0, 1, pcl, 1, mw, al, sub, asel); tick();
        drive(0, 0, 0, 0, 0, 0, 0, 2'd0);
    endtask

    task automatic test_reset();
        RESET_N = 1'b0; PROG_WE = 1'b0; PROG_ADDR = 5'd0; PROG_DATA = 8'd0; INPUT = 8'd0;
        drive(0, 0, 0, 0, 0, 0, 0, 2'd0);
        model_reset();
        repeat (2) @(negedge CLOCK);
        RESET_N = 1'b1;
        for (int i = 0; i < 32; i++) prog(5'(i), (i == 3) ? 8'h77 : 8'($urandom_range(0, 255)));
        load_a(8'h5A);
        n_checks++;
        if (A !== 8'h5A) $display("FAIL reset_preA: got %h expected 5a", A); else n_pass++;
        #3 RESET_N = 1'b0;
        #1;
        model_reset();
        n_checks++;
        if (A !== 8'h00 || PC !== 5'd0 || bus.IR !== 8'h00)
            $display("FAIL reset_regs: got A=%h PC=%h IR=%h expected 00/00/00", A, PC, bus.IR);
        else n_pass++;
        n_checks++;
        if (bus.Aeq0 !== 1'b1 || bus.Apos !== 1'b1)
            $display("FAIL reset_flags: got Aeq0=%b Apos=%b expected 1/1", bus.Aeq0, bus.Apos);
        else n_pass++;
        n_checks++;
        if (dut.u_ram.dout_q !== 8'h00) $display("FAIL reset_dout: got %h expected 00", dut.u_ram.dout_q);
        else n_pass++;
        #2 RESET_N = 1'b1;
        n_checks++;
        if (dut.u_ram.mem_q[3] !== 8'h77) $display("FAIL reset_ram_keep: got %h expected 77", dut.u_ram.mem_q[3]);
        else n_pass++;
    endtask

    task automatic test_load();
        prog(5'd0, 8'h05);  prog(5'd5, 8'h2A);
        prog(5'd1, 8'h46);  prog(5'd2, 8'h67);
        prog(5'd3, 8'h29);  prog(5'd4, 8'hB4);
        prog(5'd6, 8'h20);  prog(5'd7, 8'h11);
        prog(5'd20, 8'hBF);
        drive(0, 0, 0, 0, 0, 0, 0, 2'd0); tick();
        drive(1, 0, 1, 0, 0, 0, 0, 2'd0); tick();
        n_checks++;
        if (bus.IR !== 8'h05 || PC !== 5'd1)
            $display("FAIL load_fetch: got IR=%h PC=%h expected 05/01", bus.IR, PC);
        else n_pass++;
        drive(0, 0, 0, 1, 0, 0, 0, 2'd0); tick();
        drive(0, 0, 0, 1, 0, 1, 0, 2'd2); tick();
        n_checks++;
        if (A !== 8'h2A) $display("FAIL load_exec: got %h expected 2a", A); else n_pass++;
    endtask

    task automatic test_add_sub();
        load_a(8'hF0);
        instr(1, 2'd0, 0, 0, 0);
        n_checks++;
        if (A !== 8'h10) $display("FAIL add_wrap: got %h expected 10", A); else n_pass++;
        instr(1, 2'd0, 1, 0, 0);
        n_checks++;
        if (A !== 8'hFF || bus.Apos !== 1'b0 || bus.Aeq0 !== 1'b0)
            $display("FAIL sub_neg: got A=%h Apos=%b Aeq0=%b expected ff/0/0", A, bus.Apos, bus.Aeq0);
        else n_pass++;
    endtask

    task automatic test_store();
        load_a(8'h3C);
        instr(0, 2'd0, 0, 1, 0);
        n_checks++;
        if (bus.IR !== 8'h29 || dut.u_ram.mem_q[9] !== 8'h3C)
            $display("FAIL store: got IR=%h M9=%h expected 29/3c", bus.IR, dut.u_ram.mem_q[9]);
        else n_pass++;
        drive(0, 0, 0, 1, 1, 0, 0, 2'd0);
        PROG_WE = 1'b1; PROG_ADDR = 5'd9; PROG_DATA = 8'h11;
        tick();
        PROG_WE = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 2'd0);
        n_checks++;
        if (dut.u_ram.mem_q[9] !== 8'h11) $display("FAIL store_prog_prio: got %h expected 11", dut.u_ram.mem_q[9]);
        else n_pass++;
    endtask

    task automatic test_jump();
        drive(0, 0, 0, 0, 0, 1, 0, 2'd3); tick();
        instr(0, 2'd0, 0, 0, 1);
        n_checks++;
        if (bus.IR !== 8'hB4 || PC !== 5'd20)
            $display("FAIL jz_taken: got IR=%h PC=%0d expected b4/20", bus.IR, PC);
        else n_pass++;
        load_a(8'h01);
        drive(0, 1, 0, 1, 0, 0, 0, 2'd0); tick();
        n_checks++;
        if (PC !== 5'd20) $display("FAIL jz_not_taken: got %0d expected 20", PC); else n_pass++;
        load_a(8'h00);
        instr(0, 2'd0, 0, 0, 1);
        n_checks++;
        if (PC !== 5'd31) $display("FAIL jump_31: got %0d expected 31", PC); else n_pass++;
        drive(1, 0, 1, 0, 0, 0, 0, 2'd0); tick();
        drive(0, 0, 0, 0, 0, 0, 0, 2'd0);
        n_checks++;
        if (PC !== 5'd0) $display("FAIL pc_wrap: got %0d expected 0", PC); else n_pass++;
    endtask

    task automatic test_input();
        INPUT = 8'h80;
        drive(0, 0, 0, 0, 0, 1, 0, 2'd1);
        repeat (3) tick();
        n_checks++;
        if (A !== 8'h80 || bus.Apos !== 1'b0 || bus.Aeq0 !== 1'b0)
            $display("FAIL input: got A=%h Apos=%b Aeq0=%b expected 80/0/0", A, bus.Apos, bus.Aeq0);
        else n_pass++;
        drive(0, 0, 0, 0, 0, 1, 0, 2'd3); tick();
        drive(0, 0, 0, 0, 0, 0, 0, 2'd0);
        n_checks++;
        if (A !== 8'h00 || bus.Aeq0 !== 1'b1)
            $display("FAIL asel_reserved: got A=%h Aeq0=%b expected 00/1", A, bus.Aeq0);
        else n_pass++;
    endtask

    task automatic test_random();
        int errs;
        errs = 0;
        for (int c = 0; c < 400; c++) begin
            drive(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom_range(0, 3) == 0),
                  1'($urandom), 1'($urandom), 2'($urandom));
            INPUT     = 8'($urandom);
            PROG_WE   = ($urandom_range(0, 3) == 0);
            PROG_ADDR = 5'($urandom);
            PROG_DATA = 8'($urandom);
            tick();
            n_checks++;
            if (A !== 8'(m_a) || PC !== 5'(m_pc) || bus.IR !== 8'(m_ir) ||
                bus.Aeq0 !== (m_a == 0) || bus.Apos !== (m_a < 128)) begin
                if (errs < 10)
                    $display("FAIL random_c%0d: got A=%h PC=%0d IR=%h Z=%b P=%b expected A=%h PC=%0d IR=%h Z=%b P=%b",
                             c, A, PC, bus.IR, bus.Aeq0, bus.Apos, 8'(m_a), m_pc, 8'(m_ir), m_a == 0, m_a < 128);
                errs++;
            end else n_pass++;
        end
        PROG_WE = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 2'd0);
        for (int i = 0; i < 32; i++) begin
            n_checks++;
            if (dut.u_ram.mem_q[i] !== 8'(m_mem[i]))
                $display("FAIL random_mem%0d: got %h expected %h", i, dut.u_ram.mem_q[i], 8'(m_mem[i]));
            else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_load();
        test_add_sub();
        test_store();
        test_jump();
        test_input();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/up_datapath.md
Name: up_datapath

Overview:
- 8-bit accumulator datapath for the 8-instruction microprocessor, directly downstream of the control unit.
- Consumes the control unit's control word: IRload, JMPmux, PCload, Meminst, MemWr, Aload, Sub, Asel.
- Returns the status signals IR[7:5], Aeq0 and Apos to the control unit.
- Contains the instruction register, program counter, accumulator, adder/subtractor and a 32x8 synchronous-read RAM. The RAM has an external program-load port.

Parameters:
- DATA_W, 8, width of the accumulator, IR, RAM word and input port.
- ADDR_W, 5, width of PC and RAM address. Opcode width is fixed at DATA_W-ADDR_W = 3.
- DEPTH, 32, number of RAM words; must equal 2**ADDR_W.

Ports:
- CLOCK  in  1  single system clock; all state updates on the rising edge.
- RESET_N  in  1  asynchronous, active-low reset.
- IRload, JMPmux, PCload, Meminst, MemWr, Aload, Sub  in  1 each  control signals from the control unit.
- Asel  in  2  accumulator source select.
- INPUT  in  DATA_W  external data switches.
- PROG_WE  in  1  external RAM write enable.
- PROG_ADDR  in  ADDR_W  external RAM write address.
- PROG_DATA  in  DATA_W  external RAM write data.
- IR  out  DATA_W  instruction register; bits [7:5] are the opcode to the control unit.
- Aeq0  out  1  accumulator equals zero.
- Apos  out  1  accumulator is non-negative (A[7]==0).
- A  out  DATA_W  accumulator value, for display.
- PC  out  ADDR_W  program counter value, for display.

Behaviour:
- Reset (RESET_N low, asynchronous): IR=0, PC=0, A=0 and the RAM read register DOUT=0. Hence Aeq0=1 and Apos=1.
- RAM contents are not affected by reset.
- Reset deasserted mid-instruction: every register restarts from 0. No partial update is kept.
- RAM address mux: addr = Meminst ? IR[ADDR_W-1:0] : PC.
- RAM read is synchronous: every clock edge, DOUT <= M[addr]. DOUT is updated every cycle and is not gated by any enable.
- RAM write on the clock edge, with this priority:
  - PROG_WE=1: M[PROG_ADDR] <= PROG_DATA.
  - else MemWr=1: M[addr] <= A.
  - MemWr is ignored in any cycle where PROG_WE=1.
- Read-during-write to the same address returns the old data (read-before-write).
- IR: if IRload, IR <= DOUT on the edge; otherwise it holds.
- PC: if PCload, PC <= JMPmux ? IR[ADDR_W-1:0] : PC+1. PC+1 wraps 31 -> 0. Otherwise PC holds.
- ALU (combinational): alu = Sub ? A - DOUT : A + DOUT, computed modulo 2**DATA_W. No carry or overflow flag is produced.
- Accumulator: if Aload, A <= mux(Asel); otherwise A holds. Asel encoding:
  - 00 = alu
  - 01 = INPUT
  - 10 = DOUT
  - 11 = reserved, loads 0
- Aeq0 and Apos are combinational from the A register only. They never depend on same-cycle inputs.
- Cycle timing with the control unit (one state per clock):
  - START: addr=PC. The edge loads DOUT=M[PC].
  - FETCH: IRload=1, PCload=1. IR <= M[PC], PC <= PC+1.
  - DECODE: Meminst=1. DOUT <= M[IR[4:0]].
  - Execute state then uses DOUT: LOAD A<=DOUT; ADD/SUB A<=A±DOUT; STORE M[IR[4:0]]<=A; JZ/JPOS PC<=IR[4:0] when PCload.
- Instruction latency: 4 clocks per instruction, except INPUT, which waits for Enter.
- Halt is not an input. The datapath freezes only because the control unit drives every enable low.

Decomposition:
- Shared package (up_pkg) holds:
  - DATA_W/ADDR_W defaults.
  - Asel encodings ASEL_ALU=2'b00, ASEL_IN=2'b01, ASEL_MEM=2'b10.
  - The 3-bit opcode constants LOAD=000, STORE=001, ADD=010, SUB=011, INPUT=100, JZ=101, JPOS=110, HALT=111, shared with the control unit.
- One sub-module: up_ram.
  - DEPTH x DATA_W, single clock, synchronous read, read-before-write.
  - Two write sources resolved as above.
  - No reset on the array; DOUT is reset.

Test Plan:
- Reset: RESET_N=0 mid-cycle with A=0x5A -> A, PC, IR immediately 0; Aeq0=1, Apos=1; RAM word 3 keeps its preloaded 0x77.
- Program load, then driven control sequence START, FETCH, DECODE, LOAD on M[0]=0x05 (LOAD 5) with M[5]=0x2A -> IR=0x05 after FETCH; PC=1; A=0x2A after LOAD.
- ADD then SUB with A=0xF0 and M[6]=0x20 -> A=0x10 after ADD (wrap). SUB of M[7]=0x11 -> A=0xFF, Apos=0, Aeq0=0.
- STORE: A=0x3C, IR=0x29 (STORE 9), Meminst=1, MemWr=1 -> M[9]=0x3C. Same-cycle PROG_WE to address 9 with 0x11 -> M[9]=0x11.
- Jumps: IR=0xB4 (JZ 20), JMPmux=1, PCload=Aeq0 with A=0 -> PC=20; with A=1 -> PC unchanged. PC=31, FETCH -> PC=0.
- INPUT: Asel=01, Aload=1, INPUT=0x80 held for 3 cycles -> A=0x80, Apos=0. Asel=11 with Aload -> A=0x00, Aeq0=1.
